acq_sequencer: RTL and testbench

//  Run-control sequencer for the AXI-stream test-data generator. Latches a run config, drives the generator

---
 rtl/acq_sequencer.sv | 168 ++++++++++++++++
 tb/tb_acq_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// Run-control sequencer for the stream test-data generator: walks IDLE/ARM/RUN/DRAIN/DONE,
// drives the generator enables and monitors the stream for packet ends, drops and stalls.
//
//   state | meaning
//   IDLE  | waiting for start, gen_en=00
//   ARM   | generator counter running, output gated, gen_en=01
//   RUN   | generator fully enabled, packets counted, watchdog armed, gen_en=11
//   DRAIN | output gated again while in-flight beats are still monitored, gen_en=01
//   DONE  | one-cycle done pulse, gen_en=00
module acq_sequencer #(
    parameter int unsigned ARM_CYCLES   = 16,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_packets,
    input  logic [31:0] incr_cfg,
    output logic [1:0]  gen_en,
    output logic [31:0] gen_incr,
    input  logic        gen_tvalid,
    input  logic        gen_tlast,
    input  logic        gen_tready,
    output logic        busy,
    output logic        done,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        overflow,
    output logic        timed_out
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

    // Phase timers count down to zero; DRAIN always lasts at least one cycle.
    localparam logic [15:0]     ARM_LOAD   = 16'(ARM_CYCLES - 1);
    localparam logic [15:0]     DRAIN_LOAD = (DRAIN_CYCLES > 1) ? 16'(DRAIN_CYCLES - 1) : 16'd0;
    localparam int unsigned     IW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   IDLE_TC    = IW'(TIMEOUT - 1);

    state_t         state_q;
    logic [1:0]     gen_en_q;
    logic [31:0]    gen_incr_q;
    logic           busy_q;
    logic           done_q;
    logic [15:0]    num_pkts_q;
    logic [15:0]    pkt_count_q;
    logic [15:0]    drop_count_q;
    logic           overflow_q;
    logic           timed_out_q;
    logic [15:0]    timer_q;
    logic [IW-1:0]  idle_q;

    logic           monitor;
    logic           pkt_end;
    logic           drop_beat;
    logic           last_pkt;
    logic           timeout_hit;
    logic [15:0]    pkt_count_d;
    logic [15:0]    drop_count_d;

    assign monitor      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign pkt_end      = gen_tvalid & gen_tlast;
    assign drop_beat    = gen_tvalid & ~gen_tready;
    assign pkt_count_d  = pkt_count_q + 16'd1;
    assign drop_count_d = (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;
    assign last_pkt     = pkt_end && (num_pkts_q != 16'd0) && (pkt_count_d == num_pkts_q);
    assign timeout_hit  = (TIMEOUT != 0) && !gen_tvalid && (idle_q == IDLE_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gen_en_q     <= 2'b00;
            gen_incr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            num_pkts_q   <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            timed_out_q  <= 1'b0;
            timer_q      <= '0;
            idle_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (monitor && pkt_end) pkt_count_q <= pkt_count_d;
            if (monitor && drop_beat) begin
                drop_count_q <= drop_count_d;
                overflow_q   <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_pkts_q   <= num_packets;
                        gen_incr_q   <= incr_cfg;
                        pkt_count_q  <= '0;
                        drop_count_q <= '0;
                        overflow_q   <= 1'b0;
                        timed_out_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        idle_q       <= '0;
                        if (ARM_CYCLES == 0) begin
                            state_q  <= S_RUN;
                            gen_en_q <= 2'b11;
                        end else begin
                            state_q  <= S_ARM;
                            gen_en_q <= 2'b01;
                            timer_q  <= ARM_LOAD;
                        end
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        state_q <= S_DRAIN;
                        timer_q <= DRAIN_LOAD;
                    end else if (timer_q == 16'd0) begin
                        state_q  <= S_RUN;
                        gen_en_q <= 2'b11;
                        idle_q   <= '0;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_RUN: begin
                    if (gen_tvalid)        idle_q <= '0;
                    else if (TIMEOUT != 0) idle_q <= idle_q + 1'b1;
                    if (abort || last_pkt || timeout_hit) begin
                        state_q  <= S_DRAIN;
                        gen_en_q <= 2'b01;
                        timer_q  <= DRAIN_LOAD;
                    end
                    // An abort landing on the watchdog cycle is reported as an abort.
                    if (timeout_hit && !abort) timed_out_q <= 1'b1;
                end
                S_DRAIN: begin
                    if (timer_q == 16'd0) begin
                        state_q  <= S_DONE;
                        gen_en_q <= 2'b00;
                        done_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    gen_en_q <= 2'b00;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gen_en     = gen_en_q;
    assign gen_incr   = gen_incr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;
    assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: run results are queued when each run is launched and
// compared when the done pulse appears; timing-critical points are checked inline.
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] num_packets;
    logic [31:0] incr_cfg;
    logic [1:0]  gen_en;
    logic [31:0] gen_incr;
    logic        gen_tvalid;
    logic        gen_tlast;
    logic        gen_tready;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
    logic        overflow;
    logic        timed_out;

    always #5 clk = ~clk;

    acq_sequencer #(
        .ARM_CYCLES   (16),
        .DRAIN_CYCLES (8),
        .TIMEOUT      (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_packets (num_packets),
        .incr_cfg    (incr_cfg),
        .gen_en      (gen_en),
        .gen_incr    (gen_incr),
        .gen_tvalid  (gen_tvalid),
        .gen_tlast   (gen_tlast),
        .gen_tready  (gen_tready),
        .busy        (busy),
        .done        (done),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .timed_out   (timed_out)
    );

    typedef struct packed {
        logic [15:0] pkt;
        logic [15:0] drop;
        logic        ovf;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   d0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] p, input logic [15:0] d, input logic o, input logic t);
        exp_t e;
        e.pkt  = p;
        e.drop = d;
        e.ovf  = o;
        e.to   = t;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [15:0] n, input logic [31:0] inc);
        num_packets = n;
        incr_cfg    = inc;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic beat(input logic rdy);
        gen_tvalid = 1'b1;
        gen_tlast  = 1'b1;
        gen_tready = rdy;
        tick();
        gen_tvalid = 1'b0;
        gen_tlast  = 1'b0;
        gen_tready = 1'b1;
    endtask

    task automatic wait_en(input logic [1:0] v, input int lim);
        int n = 0;
        while (gen_en !== v && n < lim) begin
            tick();
            n++;
        end
        check("wait_gen_en", {30'd0, gen_en}, {30'd0, v});
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (done !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        check("wait_done", {31'd0, done}, 32'd1);
    endtask

    // Scoreboard: every done pulse must match the oldest launched run.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            check("sb_pending", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("sb_pkt_count",  {16'd0, pkt_count},  {16'd0, sb_e.pkt});
                check("sb_drop_count", {16'd0, drop_count}, {16'd0, sb_e.drop});
                check("sb_overflow",   {31'd0, overflow},   {31'd0, sb_e.ovf});
                check("sb_timed_out",  {31'd0, timed_out},  {31'd0, sb_e.to});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "time limit");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        num_packets = '0;
        incr_cfg    = '0;
        gen_tvalid  = 1'b0;
        gen_tlast   = 1'b0;
        gen_tready  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_gen_en",     {30'd0, gen_en}, 32'd0);
        check("rst_gen_incr",   gen_incr, 32'd0);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        check("rst_done",       {31'd0, done}, 32'd0);
        check("rst_pkt_count",  {16'd0, pkt_count}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check("rst_flags",      {30'd0, overflow, timed_out}, 32'd0);
        tick();

        // Run 1: 4 packets, exact phase timing.
        push_exp(16'd4, 16'd0, 1'b0, 1'b0);
        do_start(16'd4, 32'd4);
        check("start_gen_en", {30'd0, gen_en}, 32'd1);
        check("start_busy",   {31'd0, busy}, 32'd1);
        check("start_incr",   gen_incr, 32'd4);
        repeat (15) tick();
        check("arm_hold", {30'd0, gen_en}, 32'd1);
        tick();
        check("run_entry", {30'd0, gen_en}, 32'd3);
        for (int p = 0; p < 4; p++) begin
            repeat (19) tick();
            beat(1'b1);
            check("run1_pkt", {16'd0, pkt_count}, p + 1);
        end
        check("drain_on_last", {30'd0, gen_en}, 32'd1);
        repeat (7) tick();
        check("drain_hold_en",   {30'd0, gen_en}, 32'd1);
        check("drain_hold_done", {31'd0, done}, 32'd0);
        tick();
        check("done_pulse",  {31'd0, done}, 32'd1);
        check("done_gen_en", {30'd0, gen_en}, 32'd0);
        check("done_busy",   {31'd0, busy}, 32'd1);
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_pkt_hold", {16'd0, pkt_count}, 32'd4);

        // Run 2: 10 packets, 3 beats under backpressure.
        push_exp(16'd10, 16'd3, 1'b1, 1'b0);
        do_start(16'd10, 32'h10);
        wait_en(2'b11, 40);
        for (int i = 0; i < 10; i++) begin
            repeat (4) tick();
            beat((i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1);
        end
        check("run2_drain", {30'd0, gen_en}, 32'd1);
        wait_done(20);
        tick();

        // Run 3: continuous mode, abort after 7 packets.
        push_exp(16'd7, 16'd0, 1'b0, 1'b0);
        do_start(16'd0, 32'd1);
        wait_en(2'b11, 40);
        for (int i = 0; i < 7; i++) begin
            repeat (9) tick();
            beat(1'b1);
        end
        repeat (3) tick();
        check("run3_still_run", {30'd0, gen_en}, 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_drain", {30'd0, gen_en}, 32'd1);
        check("abort_pkt",   {16'd0, pkt_count}, 32'd7);
        check("abort_no_to", {31'd0, timed_out}, 32'd0);
        wait_done(20);
        tick();

        // Run 4: stall after two packets trips the watchdog 100 cycles after the last beat.
        push_exp(16'd2, 16'd0, 1'b0, 1'b1);
        do_start(16'd0, 32'd2);
        wait_en(2'b11, 40);
        for (int i = 0; i < 2; i++) begin
            repeat (9) tick();
            beat(1'b1);
        end
        repeat (99) tick();
        check("wd_not_yet",    {31'd0, timed_out}, 32'd0);
        check("wd_not_yet_en", {30'd0, gen_en}, 32'd3);
        tick();
        check("wd_fired",    {31'd0, timed_out}, 32'd1);
        check("wd_drain_en", {30'd0, gen_en}, 32'd1);
        wait_done(20);
        tick();
        check("wd_flag_held", {31'd0, timed_out}, 32'd1);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_ignored", {31'd0, busy}, 32'd0);

        // Run 5: start ignored mid-run, then reset mid-run (no done expected).
        do_start(16'd5, 32'd8);
        check("start_clears_to", {31'd0, timed_out}, 32'd0);
        wait_en(2'b11, 40);
        for (int i = 0; i < 2; i++) begin
            repeat (4) tick();
            beat(1'b1);
        end
        num_packets = 16'd9;
        incr_cfg    = 32'd77;
        start       = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_en",   {30'd0, gen_en}, 32'd3);
        check("rerun_incr", gen_incr, 32'd8);
        check("rerun_pkt",  {16'd0, pkt_count}, 32'd2);
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_en",   {30'd0, gen_en}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_pkt",  {16'd0, pkt_count}, 32'd0);
        check("midrst_incr", gen_incr, 32'd0);
        repeat (12) tick();
        check("midrst_no_done", done_cnt, d0);

        // Run 6: final tlast and abort on the same cycle.
        push_exp(16'd3, 16'd0, 1'b0, 1'b0);
        do_start(16'd3, 32'd5);
        wait_en(2'b11, 40);
        for (int i = 0; i < 2; i++) begin
            repeat (4) tick();
            beat(1'b1);
        end
        repeat (4) tick();
        abort = 1'b1;
        beat(1'b1);
        abort = 1'b0;
        check("last_abort_en",  {30'd0, gen_en}, 32'd1);
        check("last_abort_pkt", {16'd0, pkt_count}, 32'd3);
        d0 = done_cnt;
        repeat (7) tick();
        check("last_abort_drain", {31'd0, done}, 32'd0);
        tick();
        check("last_abort_done", {31'd0, done}, 32'd1);
        repeat (3) tick();
        check("single_done", done_cnt, d0 + 1);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
